// File: rtl/pic_interrupt_sequencer.sv
// 8259-style PIC control sequencer: raises INT, runs the two-pulse INTA
// handshake, drives the vector byte and executes EOI / priority rotation.
module pic_interrupt_sequencer #(
    parameter logic [2:0] ROTATE_RESET = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       eoi_rotate,
    input  logic       auto_eoi,
    input  logic       auto_rotate,
    input  logic [4:0] vector_base,
    output logic       int_out,
    output logic [7:0] in_service_register,
    output logic [7:0] clear_irr,
    output logic [2:0] priority_rotate,
    output logic [7:0] data_out,
    output logic       data_out_en
);

    typedef enum logic [2:0] {IDLE, REQ, ACK1, ACK2, ACK2_END} state_t;

    state_t     state_q, state_d;
    logic       inta_prev_q;
    logic [7:0] isr_q, isr_d;
    logic [7:0] clear_irr_q, clear_irr_d;
    logic [2:0] rotate_q, rotate_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spurious_q, spurious_d;
    logic [7:0] data_q, data_d;
    logic       data_en_q, data_en_d;
    logic       int_q, int_d;

    logic       fall, rise;
    logic [2:0] req_lvl;
    logic [2:0] search_idx;
    logic       eoi_hit;
    logic [2:0] eoi_clr_lvl;
    logic       aeoi_clr;
    logic [7:0] isr_set, isr_clr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            inta_prev_q <= 1'b1;
            isr_q       <= '0;
            clear_irr_q <= '0;
            rotate_q    <= ROTATE_RESET;
            lvl_q       <= '0;
            spurious_q  <= 1'b0;
            data_q      <= '0;
            data_en_q   <= 1'b0;
            int_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            inta_prev_q <= inta_n;
            isr_q       <= isr_d;
            clear_irr_q <= clear_irr_d;
            rotate_q    <= rotate_d;
            lvl_q       <= lvl_d;
            spurious_q  <= spurious_d;
            data_q      <= data_d;
            data_en_q   <= data_en_d;
            int_q       <= int_d;
        end
    end

    always_comb begin
        fall = inta_prev_q & ~inta_n;
        rise = ~inta_prev_q & inta_n;

        // Lowest set index wins if the resolver ever presents more than one bit.
        req_lvl = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (interrupt[i]) req_lvl = 3'(i);
        end

        // Non-specific EOI searches upward from the level just above the lowest priority.
        eoi_hit     = 1'b0;
        eoi_clr_lvl = 3'd0;
        search_idx  = 3'd0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_clr_lvl = eoi_level;
                eoi_hit     = isr_q[eoi_level];
            end else begin
                for (int i = 0; i < 8; i++) begin
                    search_idx = rotate_q + 3'd1 + 3'(i);
                    if (!eoi_hit && isr_q[search_idx]) begin
                        eoi_hit     = 1'b1;
                        eoi_clr_lvl = search_idx;
                    end
                end
            end
        end

        state_d     = state_q;
        lvl_d       = lvl_q;
        spurious_d  = spurious_q;
        data_d      = data_q;
        data_en_d   = data_en_q;
        int_d       = int_q;
        clear_irr_d = '0;
        isr_set     = '0;
        aeoi_clr    = 1'b0;

        case (state_q)
            IDLE: begin
                if (interrupt != 8'd0) begin
                    state_d = REQ;
                    int_d   = 1'b1;
                end
            end
            REQ: begin
                if (fall) begin
                    int_d   = 1'b0;
                    state_d = ACK1;
                    if (interrupt != 8'd0) begin
                        lvl_d       = req_lvl;
                        spurious_d  = 1'b0;
                        isr_set     = 8'd1 << req_lvl;
                        clear_irr_d = 8'd1 << req_lvl;
                    end else begin
                        lvl_d      = 3'd7;
                        spurious_d = 1'b1;
                    end
                end else if (interrupt == 8'd0) begin
                    int_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            ACK1: begin
                if (fall) begin
                    state_d   = ACK2;
                    data_d    = {vector_base, lvl_q};
                    data_en_d = 1'b1;
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d   = IDLE;
                    data_d    = '0;
                    data_en_d = 1'b0;
                    aeoi_clr  = auto_eoi & ~spurious_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clears apply before the set, so a same-cycle set of the same bit survives.
        isr_clr = (eoi_hit  ? (8'd1 << eoi_clr_lvl) : 8'd0)
                | (aeoi_clr ? (8'd1 << lvl_q)       : 8'd0);
        isr_d   = (isr_q & ~isr_clr) | isr_set;

        rotate_d = rotate_q;
        if (eoi_hit && eoi_rotate)
            rotate_d = eoi_clr_lvl;
        else if (aeoi_clr && auto_rotate)
            rotate_d = lvl_q;
    end

    assign int_out             = int_q;
    assign in_service_register = isr_q;
    assign clear_irr           = clear_irr_q;
    assign priority_rotate     = rotate_q;
    assign data_out            = data_q;
    assign data_out_en         = data_en_q;

endmodule

// File: doc/pic_interrupt_sequencer.md
Name: pic_interrupt_sequencer

Overview:
- Control-logic sequencer for the 8259-style PIC.
- Consumes the one-hot `interrupt` result of the priority resolver and raises INT to the CPU.
- Runs the two-pulse 8086 INTA handshake: latches the winner into the ISR, pulses IRR clear, and drives the vector byte.
- Executes EOI commands (specific, non-specific, auto, rotating) and owns the `priority_rotate` value fed back to the resolver.

Parameters:
- ROTATE_RESET, 3'b111, reset value of `priority_rotate` (111 makes IR0 highest priority, IR7 lowest).

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- interrupt  in  8  one-hot highest-priority unmasked request from the priority resolver; 0 means none
- inta_n  in  1  CPU interrupt acknowledge, active low, already synchronous to clock
- eoi_valid  in  1  one-cycle EOI command strobe
- eoi_specific  in  1  1 means specific EOI at eoi_level; 0 means non-specific
- eoi_level  in  3  IR level for a specific EOI
- eoi_rotate  in  1  rotate priority on this EOI
- auto_eoi  in  1  AEOI mode: clear the ISR bit at the end of the second INTA pulse
- auto_rotate  in  1  rotate on AEOI
- vector_base  in  5  ICW2 T7..T3
- int_out  out  1  INT to CPU
- in_service_register  out  8  ISR, fed to the priority resolver
- clear_irr  out  8  one-cycle one-hot pulse that clears the acknowledged IRR bit
- priority_rotate  out  3  current lowest-priority level, fed to the priority resolver
- data_out  out  8  vector byte
- data_out_en  out  1  data bus drive enable

Behaviour:
- Reset: asynchronous, active-high. All outputs 0 except `priority_rotate`=ROTATE_RESET. State=IDLE, internal `inta_n` history=1. A reset mid-handshake aborts it with no ISR change.
- Edge detection: fall = (prev `inta_n`==1 and `inta_n`==0); rise = (prev 0, now 1). Prev is a register.
- States: IDLE, REQ, ACK1, ACK2, ACK2_END.
- IDLE -> REQ when `interrupt`!=0. `int_out` goes high the same edge, so it is visible 1 cycle after `interrupt` appears.
- REQ:
  - On fall: latch `lvl` = encode(`interrupt`) and set ISR[`lvl`]. Pulse `clear_irr`[`lvl`] for exactly 1 cycle. Drop `int_out`. Go to ACK1.
  - If `interrupt`==0 at that fall (request withdrawn), it is a spurious acknowledge: `lvl`=7, no ISR set, no `clear_irr`. Go to ACK1.
- REQ -> IDLE with `int_out` dropped if `interrupt` returns to 0 with no fall.
- ACK1: first pulse, no bus drive. On fall go to ACK2 with `data_out` = {`vector_base`, `lvl`} and `data_out_en`=1 from the next cycle.
- ACK2: hold `data_out`/`data_out_en` until rise. On rise: `data_out_en`=0, `data_out`=0, go to IDLE.
  - If `auto_eoi`=1 and the acknowledge was not spurious, also clear ISR[`lvl`].
  - If additionally `auto_rotate`=1, set `priority_rotate`=`lvl`.
- ACK2_END is not used as a resting state; the return to IDLE is direct. A new request may raise `int_out` the cycle after.
- Non-specific EOI: clear the highest-priority set ISR bit. Search starts at level (`priority_rotate`+1) mod 8 and wraps upward. ISR==0 is a no-op.
- Specific EOI: clear ISR[`eoi_level`]. Already clear is a no-op.
- EOI rotate: if `eoi_rotate`=1 and a bit was actually cleared, `priority_rotate` = cleared level. Otherwise unchanged.
- EOI is accepted in every state.
- Same-cycle ISR clear (EOI or AEOI) and ISR set: the clear is applied first, then the set, so a set of the same bit wins.
- Same-cycle EOI rotate and AEOI rotate: EOI wins.
- Widths:
  - `lvl` and `priority_rotate` arithmetic is mod 8.
  - `interrupt` is assumed one-hot. If multiple bits are set, the lowest-index bit is encoded.

Test Plan:
- Reset then `interrupt`=8'h08: `int_out`=1 one cycle later. First INTA fall: ISR=8'h08, `clear_irr`=8'h08 for one cycle, `int_out`=0. Second INTA low: `data_out`=8'h23 (base 5'b00100), `data_out_en`=1. Rise: `data_out_en`=0, ISR stays 8'h08.
- ISR=8'h28, `priority_rotate`=111, non-specific EOI -> ISR=8'h20. Repeat with `eoi_rotate`=1 from ISR=8'h28 -> ISR=8'h20, `priority_rotate`=3.
- `auto_eoi`=1, `auto_rotate`=1, request on IR5: after second INTA rise ISR=0 and `priority_rotate`=5. The next `interrupt`=8'h01 acknowledges with vector {base,0}.
- `interrupt`=8'h04, then forced to 0 before the first INTA fall: `int_out` drops, state returns to IDLE. Separately, withdraw exactly at the fall: ISR unchanged, `clear_irr`=0, vector={base,3'b111}.
- Specific EOI level 2 in the same cycle as the first INTA fall for IR2 with ISR already 8'h04: ISR=8'h04 after the edge (set wins), `clear_irr`=8'h04.
- Assert reset while in ACK2 with `data_out_en`=1: all outputs return to reset values immediately, asynchronously, and `priority_rotate`=111.
